// File: rtl/comm_delay.sv
// Delay commutator for a radix-2 SDF FFT stage: pairs each sample with the one
// DEPTH valid samples later, alternating lanes in blocks of DEPTH pairs.
`ifndef Nbitsg
`define Nbitsg 16
`endif

module comm_delay #(
    parameter int unsigned Nbits = `Nbitsg,
    parameter int unsigned DLOG  = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic [2*Nbits-1:0]   in_up,
    input  logic [2*Nbits-1:0]   in_down,
    output logic                 out_valid,
    output logic [2*Nbits-1:0]   out_up,
    output logic [2*Nbits-1:0]   out_down
);

    localparam int unsigned W     = 2 * Nbits;
    localparam int unsigned CW    = DLOG + 1;
    localparam int unsigned DEPTH = 32'd1 << DLOG;

    logic [CW-1:0] cnt;
    logic          phase;
    logic          primed;

    logic [W-1:0]  d_in_sr  [DEPTH];
    logic [W-1:0]  d_bot_sr [DEPTH];
    logic [W-1:0]  d_in;
    logic [W-1:0]  d_bot;
    logic [W-1:0]  sw_top;
    logic [W-1:0]  sw_bot;

    assign phase = cnt[DLOG];
    assign d_in  = d_in_sr[DEPTH-1];
    assign d_bot = d_bot_sr[DEPTH-1];

    // Lane switch: phase 1 crosses the delayed upper lane onto the bottom path
    always_comb begin
        sw_top = d_in;
        sw_bot = in_down;
        if (phase) begin
            sw_top = in_down;
            sw_bot = d_in;
        end
    end

    // Input-side delay line on the upper lane
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                d_in_sr[i] <= '0;
            end
        end else if (in_valid) begin
            d_in_sr[0] <= in_up;
            for (int i = 1; i < int'(DEPTH); i++) begin
                d_in_sr[i] <= d_in_sr[i-1];
            end
        end
    end

    // Output-side delay line on the switched bottom lane
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                d_bot_sr[i] <= '0;
            end
        end else if (in_valid) begin
            d_bot_sr[0] <= sw_bot;
            for (int i = 1; i < int'(DEPTH); i++) begin
                d_bot_sr[i] <= d_bot_sr[i-1];
            end
        end
    end

    // Counter, priming and output pair registers; phase=1 first occurs at index DEPTH
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            primed    <= 1'b0;
            out_valid <= 1'b0;
            out_up    <= '0;
            out_down  <= '0;
        end else begin
            out_valid <= in_valid && (primed || phase);
            if (in_valid) begin
                cnt      <= cnt + CW'(1);
                out_up   <= d_bot;
                out_down <= sw_top;
                if (phase) begin
                    primed <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_comm_delay.sv
// Directed bench for comm_delay: three instances (DLOG 0, 2, 6) share one input
// stream; each test targets one or more of them.
module tb_comm_delay;

    localparam int unsigned NB = 16;
    localparam int unsigned W  = 2 * NB;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic [W-1:0]  in_up;
    logic [W-1:0]  in_down;
    logic          ov [3];
    logic [W-1:0]  ou [3];
    logic [W-1:0]  od [3];

    int unsigned   depth_of [3] = '{1, 4, 64};
    int            n_tests = 0;
    int            n_fail  = 0;
    logic [W-1:0]  sa [256];
    logic [W-1:0]  sb [256];

    always #5 clk = ~clk;

    comm_delay #(.Nbits(NB), .DLOG(0)) u_d0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_up(in_up), .in_down(in_down),
        .out_valid(ov[0]), .out_up(ou[0]), .out_down(od[0])
    );
    comm_delay #(.Nbits(NB), .DLOG(2)) u_d2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_up(in_up), .in_down(in_down),
        .out_valid(ov[1]), .out_up(ou[1]), .out_down(od[1])
    );
    comm_delay #(.Nbits(NB), .DLOG(6)) u_d6 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_up(in_up), .in_down(in_down),
        .out_valid(ov[2]), .out_up(ou[2]), .out_down(od[2])
    );

    // Drive one cycle of inputs, then land 1 time unit past the rising edge
    task automatic step(input logic r, input logic v, input logic [W-1:0] u, input logic [W-1:0] d);
        rst      = r;
        in_valid = v;
        in_up    = u;
        in_down  = d;
        @(posedge clk);
        #1;
    endtask

    // DEPTH=4 pair pattern: blocks of 4 lower-lane pairs, then 4 upper-lane pairs, indices +8 per round
    task automatic pat4(input int m, input logic [W-1:0] bu, input logic [W-1:0] bd,
                        output logic [W-1:0] eu, output logic [W-1:0] ed);
        int blk;
        int off;
        blk = m / 4;
        off = 8 * (blk / 2) + (m % 4);
        if (blk % 2 == 0) begin
            eu = bd + W'(off);
            ed = bd + W'(off + 4);
        end else begin
            eu = bu + W'(off);
            ed = bu + W'(off + 4);
        end
    endtask

    // Reference order: lower-lane pair (b[k-D], b[k]) in odd blocks, upper-lane (a[k-2D], a[k-D]) in even
    task automatic ref_pair(input int k, input int dep, output logic [W-1:0] eu, output logic [W-1:0] ed);
        if ((k / dep) % 2 == 1) begin
            eu = sb[k - dep];
            ed = sb[k];
        end else begin
            eu = sa[k - 2 * dep];
            ed = sa[k - dep];
        end
    endtask

    task automatic test_reset();
        for (int c = 0; c < 4; c++) begin
            step(1'b1, 1'b1, 32'hFFFF_FFFF, 32'h5A5A_A5A5);
            for (int i = 0; i < 3; i++) begin
                n_tests++;
                if ({ov[i], ou[i], od[i]} !== {1'b0, 32'h0, 32'h0}) begin
                    n_fail++;
                    $display("FAIL reset_hold inst%0d cyc%0d: got v=%b up=%h dn=%h, want v=0 up=0 dn=0",
                             i, c, ov[i], ou[i], od[i]);
                end
            end
        end
    endtask

    task automatic test_dlog0();
        logic [W-1:0] a [5];
        logic [W-1:0] b [5];
        logic [W-1:0] eu [4];
        logic [W-1:0] ed [4];
        for (int k = 0; k < 5; k++) begin
            a[k] = 32'hA000_0000 + W'(k);
            b[k] = 32'hB000_0000 + W'(k);
        end
        eu = '{b[0], a[0], b[2], a[2]};
        ed = '{b[1], a[1], b[3], a[3]};
        step(1'b1, 1'b0, '0, '0);
        for (int k = 0; k < 5; k++) begin
            step(1'b0, 1'b1, a[k], b[k]);
            n_tests++;
            if (k == 0) begin
                if (ov[0] !== 1'b0) begin
                    n_fail++;
                    $display("FAIL dlog0_first_invalid: got v=%b, want v=0", ov[0]);
                end
            end else if ({ov[0], ou[0], od[0]} !== {1'b1, eu[k-1], ed[k-1]}) begin
                n_fail++;
                $display("FAIL dlog0_pair%0d: got v=%b up=%h dn=%h, want v=1 up=%h dn=%h",
                         k - 1, ov[0], ou[0], od[0], eu[k-1], ed[k-1]);
            end
        end
    endtask

    task automatic test_dlog2();
        logic [W-1:0] eu;
        logic [W-1:0] ed;
        step(1'b1, 1'b0, '0, '0);
        for (int k = 0; k < 16; k++) begin
            step(1'b0, 1'b1, 32'h100 + W'(k), 32'h200 + W'(k));
            n_tests++;
            if (k < 4) begin
                if (ov[1] !== 1'b0) begin
                    n_fail++;
                    $display("FAIL dlog2_prime k=%0d: got v=%b, want v=0", k, ov[1]);
                end
            end else begin
                pat4(k - 4, 32'h100, 32'h200, eu, ed);
                if ({ov[1], ou[1], od[1]} !== {1'b1, eu, ed}) begin
                    n_fail++;
                    $display("FAIL dlog2_pair k=%0d: got v=%b up=%h dn=%h, want v=1 up=%h dn=%h",
                             k, ov[1], ou[1], od[1], eu, ed);
                end
            end
        end
    endtask

    task automatic test_gaps();
        logic [W-1:0] eu;
        logic [W-1:0] ed;
        logic [W-1:0] hu;
        logic [W-1:0] hd;
        hu = '0;
        hd = '0;
        step(1'b1, 1'b0, '0, '0);
        for (int k = 0; k < 16; k++) begin
            step(1'b0, 1'b1, 32'h100 + W'(k), 32'h200 + W'(k));
            if (k >= 4) begin
                pat4(k - 4, 32'h100, 32'h200, eu, ed);
                hu = eu;
                hd = ed;
                n_tests++;
                if ({ov[1], ou[1], od[1]} !== {1'b1, eu, ed}) begin
                    n_fail++;
                    $display("FAIL gap_pair k=%0d: got v=%b up=%h dn=%h, want v=1 up=%h dn=%h",
                             k, ov[1], ou[1], od[1], eu, ed);
                end
            end
            if (k % 5 == 4) begin
                for (int g = 0; g < 3; g++) begin
                    step(1'b0, 1'b0, $urandom, $urandom);
                    n_tests++;
                    if ({ov[1], ou[1], od[1]} !== {1'b0, hu, hd}) begin
                        n_fail++;
                        $display("FAIL gap_hold k=%0d g=%0d: got v=%b up=%h dn=%h, want v=0 up=%h dn=%h",
                                 k, g, ov[1], ou[1], od[1], hu, hd);
                    end
                end
            end
        end
    endtask

    task automatic test_mid_reset();
        logic [W-1:0] eu;
        logic [W-1:0] ed;
        step(1'b1, 1'b0, '0, '0);
        for (int k = 0; k < 7; k++) begin
            step(1'b0, 1'b1, 32'h100 + W'(k), 32'h200 + W'(k));
        end
        step(1'b1, 1'b1, 32'hDEAD_0001, 32'hBEEF_0002);
        n_tests++;
        if ({ov[1], ou[1], od[1]} !== {1'b0, 32'h0, 32'h0}) begin
            n_fail++;
            $display("FAIL midrst_clear: got v=%b up=%h dn=%h, want v=0 up=0 dn=0", ov[1], ou[1], od[1]);
        end
        for (int k = 0; k < 16; k++) begin
            step(1'b0, 1'b1, 32'h300 + W'(k), 32'h400 + W'(k));
            n_tests++;
            if (k < 4) begin
                if ({ov[1], ou[1], od[1]} !== {1'b0, 32'h0, 32'h0}) begin
                    n_fail++;
                    $display("FAIL midrst_prime k=%0d: got v=%b up=%h dn=%h, want v=0 up=0 dn=0",
                             k, ov[1], ou[1], od[1]);
                end
            end else begin
                pat4(k - 4, 32'h300, 32'h400, eu, ed);
                if ({ov[1], ou[1], od[1]} !== {1'b1, eu, ed}) begin
                    n_fail++;
                    $display("FAIL midrst_pair k=%0d: got v=%b up=%h dn=%h, want v=1 up=%h dn=%h",
                             k, ov[1], ou[1], od[1], eu, ed);
                end
            end
        end
    endtask

    task automatic test_random();
        logic [W-1:0] eu;
        logic [W-1:0] ed;
        int           nvalid;
        nvalid = 0;
        for (int k = 0; k < 256; k++) begin
            sa[k] = $urandom;
            sb[k] = $urandom;
        end
        step(1'b1, 1'b0, '0, '0);
        for (int k = 0; k < 256; k++) begin
            step(1'b0, 1'b1, sa[k], sb[k]);
            if (ov[2] === 1'b1) nvalid++;
            for (int i = 0; i < 3; i++) begin
                n_tests++;
                if (k < int'(depth_of[i])) begin
                    if (ov[i] !== 1'b0) begin
                        n_fail++;
                        $display("FAIL rand_prime inst%0d k=%0d: got v=%b, want v=0", i, k, ov[i]);
                    end
                end else begin
                    ref_pair(k, int'(depth_of[i]), eu, ed);
                    if ({ov[i], ou[i], od[i]} !== {1'b1, eu, ed}) begin
                        n_fail++;
                        $display("FAIL rand_pair inst%0d k=%0d: got v=%b up=%h dn=%h, want v=1 up=%h dn=%h",
                                 i, k, ov[i], ou[i], od[i], eu, ed);
                    end
                end
            end
        end
        n_tests++;
        if (nvalid != 192) begin
            n_fail++;
            $display("FAIL rand_pair_count: got %0d, want 192", nvalid);
        end
    endtask

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        in_up    = '0;
        in_down  = '0;
        test_reset();
        test_dlog0();
        test_dlog2();
        test_gaps();
        test_mid_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
